// File: rtl/rx_specified_len_check_pkg.sv
// Shared types and constants for the length-driven receive checker.
package rx_specified_len_check_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    localparam int RPT_BYTES = 8;
    localparam int LEN_BYTES = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/rx_specified_len_check_if.sv
// Byte-stream input, report-stream output and status flags of the checker.
interface rx_specified_len_check_if;
    logic       i_tready;
    logic       i_tvalid;
    logic [7:0] i_tdata;
    logic       o_tready;
    logic       o_tvalid;
    logic [7:0] o_tdata;
    logic       o_tlast;
    logic       o_err;
    logic       o_busy;

    modport master (
        output i_tvalid, i_tdata, o_tready,
        input  i_tready, o_tvalid, o_tdata, o_tlast, o_err, o_busy
    );

    modport slave (
        input  i_tvalid, i_tdata, o_tready,
        output i_tready, o_tvalid, o_tdata, o_tlast, o_err, o_busy
    );
endinterface

// File: rtl/rx_specified_len_check.sv
// Parses {len32, payload} packets, checks payload against an incrementing
// pattern starting at SEED, then emits an 8-byte {len, error count} report.
module rx_specified_len_check
    import rx_specified_len_check_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h00
) (
    input logic                     clk,
    input logic                     rstn,
    rx_specified_len_check_if.slave bus
);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  hdr_idx;
    logic [2:0]  rpt_idx;
    logic [31:0] len;
    logic [31:0] k;
    logic [31:0] err_cnt;
    logic        err_flag;
    logic        in_fire;
    logic        out_fire;
    logic        hdr_done;
    logic        data_done;
    logic        rpt_done;
    logic [31:0] len_full;
    logic [7:0]  rpt_byte;

    function automatic logic [7:0] expected_byte(input logic [7:0] idx);
        return SEED + idx;
    endfunction

    assign in_fire   = bus.i_tvalid & bus.i_tready;
    assign out_fire  = bus.o_tvalid & bus.o_tready;
    assign len_full  = {bus.i_tdata, len[23:0]};
    assign hdr_done  = (state == ST_HDR) && in_fire && (hdr_idx == 2'(LEN_BYTES - 1));
    // len is at least 1 whenever DATA is entered, so len - 1 cannot wrap.
    assign data_done = (state == ST_DATA) && in_fire && (k == len - 32'd1);
    assign rpt_done  = (state == ST_RPT) && out_fire && (rpt_idx == 3'(RPT_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_HDR: begin
                if (hdr_done) begin
                    state_nxt = (len_full == 32'd0) ? ST_RPT : ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_done) begin
                    state_nxt = ST_RPT;
                end
            end
            ST_RPT: begin
                if (rpt_done) begin
                    state_nxt = ST_HDR;
                end
            end
            default: state_nxt = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hdr_idx  <= 2'd0;
            rpt_idx  <= 3'd0;
            len      <= 32'd0;
            k        <= 32'd0;
            err_cnt  <= 32'd0;
            err_flag <= 1'b0;
        end else begin
            unique case (state)
                ST_HDR: begin
                    if (in_fire) begin
                        len[{hdr_idx, 3'b000} +: 8] <= bus.i_tdata;
                        hdr_idx                     <= hdr_idx + 2'd1;
                        if (hdr_done) begin
                            k       <= 32'd0;
                            err_cnt <= 32'd0;
                        end
                    end
                end
                ST_DATA: begin
                    if (in_fire) begin
                        if (bus.i_tdata != expected_byte(k[7:0])) begin
                            err_cnt  <= sat_inc(err_cnt);
                            err_flag <= 1'b1;
                        end
                        k <= k + 32'd1;
                    end
                end
                ST_RPT: begin
                    // Index wraps back to 0 after byte 7, ready for the next report.
                    if (out_fire) begin
                        rpt_idx <= rpt_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rpt_byte = rpt_idx[2] ? err_cnt[{rpt_idx[1:0], 3'b000} +: 8]
                                 : len[{rpt_idx[1:0], 3'b000} +: 8];

    assign bus.i_tready = (state == ST_HDR) || (state == ST_DATA);
    assign bus.o_tvalid = (state == ST_RPT);
    assign bus.o_tdata  = (state == ST_RPT) ? rpt_byte : 8'h00;
    assign bus.o_tlast  = (state == ST_RPT) && (rpt_idx == 3'(RPT_BYTES - 1));
    assign bus.o_err    = err_flag;
    assign bus.o_busy   = (state != ST_HDR) || (hdr_idx != 2'd0);

endmodule

// File: doc/rx_specified_len_check.md
# rx_specified_len_check

Receive-side counterpart of the length-driven mass-transmit test. It consumes the 8-bit RX AXI-stream coming out of `ftdi_245fifo_top` (RX_EW=0). Each packet is a 4-byte little-endian length N followed by N payload bytes. The block checks every payload byte against an incrementing pattern, then returns an 8-byte report on its output stream, which feeds the TX side of `ftdi_245fifo_top`. This lets host software measure host→FPGA throughput and integrity.

## Interface
- `SEED`, default 8'h00: expected value of payload byte 0. Byte k is expected to equal (SEED + k) mod 256.
- `clk`  in  1: sole clock (the user-side clock, e.g. clk_100).
- `rstn`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `i_tready`  out  1: input ready.
- `i_tvalid`  in  1: input valid.
- `i_tdata`  in  8: input byte.
- `o_tready`  in  1: report ready.
- `o_tvalid`  out  1: report valid.
- `o_tdata`  out  8: report byte.
- `o_tlast`  out  1: high on report byte 7.
- `o_err`  out  1: sticky flag; set when any mismatch is found since reset.
- `o_busy`  out  1: high while state ≠ HDR or the header byte count ≠ 0.

## Operation
- Input transfer = `i_tvalid & i_tready`. Output transfer = `o_tvalid & o_tready`.
- States:
  - **HDR**: `i_tready`=1. Accepted bytes fill len[7:0], [15:8], [23:16], [31:24] in that order, tracked by a 2-bit index. On the 4th byte: if N==0 go to RPT, else go to DATA. Clear the payload index k and the error count at that point.
  - **DATA**: `i_tready`=1. On each accepted byte, compare it to (SEED+k)[7:0]. On mismatch, increment the error count (32-bit, saturating at 32'hFFFF_FFFF) and set `o_err`. Then increment k. When the byte with k==N−1 is accepted, go to RPT.
  - **RPT**: `i_tready`=0, `o_tvalid`=1. Emit bytes 0-3 = N (little-endian), then bytes 4-7 = error count (little-endian). `o_tlast`=1 on byte 7 only. On transfer of byte 7, go to HDR.
- k and N are 32-bit; the comparison k==N−1 is evaluated without overflow (N≥1 in DATA).
- Bytes arriving during RPT are back-pressured, never dropped.
- `o_err` clears only on reset. It is not cleared per packet.
- Reset values: state=HDR, header index=0, N=0, k=0, error count=0, `o_tvalid`=0, `o_tdata`=0, `o_tlast`=0, `o_err`=0, `o_busy`=0. `i_tready`=1 in the first cycle after reset is released.
- Reset asserted mid-packet or mid-report abandons it immediately. No partial report is emitted.

## Timing
- `i_tready`, `o_tvalid` and `o_tlast` decode directly from registered state. There is no combinational path from `i_tvalid` or `o_tready` to any output.
- The last payload byte is accepted in cycle t. `o_tvalid` rises at t+1.
- With N==0, the 4th header byte is accepted in cycle t and `o_tvalid` rises at t+1.
- Throughput: 1 byte/cycle in HDR and DATA. With `o_tready` held high, the report takes 8 cycles.
- While `o_tvalid`=1 and `o_tready`=0, `o_tdata` and `o_tlast` hold stable.
- `i_tready` rises the cycle after byte 7 is transferred.
- A mismatch on byte k is reflected in the error count and `o_err` at the next edge. The report always includes the final byte's result.

## Structure
- Shared package holds:
  - the state encoding (HDR, DATA, RPT);
  - `RPT_BYTES`=8;
  - `LEN_BYTES`=4.
- Single flat module. A byte mux selecting among {N, error count} by a 3-bit report index is sufficient, so no sub-module is needed.
- Top-level example pairs this block with `ftdi_245fifo_top` (RX_EW=0, TX_EW=0), with `rstn` driven from a power-on synchronous reset.

## Test plan
- Header 10 00 00 00, then bytes 00..0F, `o_tready`=1 → report 10 00 00 00 00 00 00 00; `o_tlast` on byte 7; `o_err`=0.
- N=5 with payload 00 01 FF 03 04 → report 05 00 00 00 01 00 00 00; `o_err`=1 and stays 1 through the next clean packet.
- Header 00 00 00 00 → report 00 00 00 00 00 00 00 00 the next cycle; no payload bytes consumed.
- N=300 with pattern wrapping FF→00, `i_tvalid` randomly gapped, `o_tready` toggling every cycle → error count 0. `o_tdata` is stable while stalled. `i_tready`=0 throughout the report.
- SEED=8'hA5, N=3, payload A5 A6 A7 → error count 0. Send a second packet back-to-back while the report is stalled; it is accepted only after byte 7 transfers.
- `rstn` low for 1 cycle during payload byte 7 of N=20 → no report emitted. Next header 02 00 00 00 plus 00 01 gives report 02 00 00 00 00 00 00 00.
